// File: rtl/wb_port_arbiter.sv
// Round-robin writeback arbiter: one 1-entry buffer per requester feeding
// a single registered writeback port toward the scoreboard.
package wb_port_arbiter_pkg;

   localparam int XLEN = 64;

   typedef struct packed {
      int unsigned NrScoreboardEntries;
   } cfg_t;

   localparam cfg_t cva6_cfg_empty = '{NrScoreboardEntries: 8};

   typedef struct packed {
      logic [XLEN-1:0] cause;
      logic [XLEN-1:0] tval;
      logic            valid;
   } exception_t;

endpackage

module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter cfg_t CVA6Cfg = cva6_cfg_empty,
   parameter int   NrPorts = 4,
   localparam int  TidW    = $clog2(CVA6Cfg.NrScoreboardEntries),
   localparam int  PW      = $clog2(NrPorts)
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           flush_i,
   input  logic [NrPorts-1:0]             req_valid_i,
   output logic [NrPorts-1:0]             req_ready_o,
   input  logic [NrPorts-1:0][XLEN-1:0]   req_result_i,
   input  logic [NrPorts-1:0][TidW-1:0]   req_trans_id_i,
   input  exception_t [NrPorts-1:0]       req_exception_i,
   output logic                           wb_valid_o,
   input  logic                           wb_ready_i,
   output logic [XLEN-1:0]                wb_result_o,
   output logic [TidW-1:0]                wb_trans_id_o,
   output exception_t                     wb_exception_o,
   output logic [PW-1:0]                  wb_src_o
);

   logic [NrPorts-1:0]           buf_valid;
   logic [NrPorts-1:0][XLEN-1:0] buf_result;
   logic [NrPorts-1:0][TidW-1:0] buf_tid;
   exception_t [NrPorts-1:0]     buf_exc;

   logic                         out_valid;
   logic [XLEN-1:0]              out_result;
   logic [TidW-1:0]              out_tid;
   exception_t                   out_exc;
   logic [PW-1:0]                out_src;

   logic [PW-1:0]                rr_ptr;
   logic [PW-1:0]                nxt_ptr;
   logic                         out_free;
   logic                         gnt_any;
   logic [PW-1:0]                gnt_idx;
   logic [NrPorts-1:0]           grant;
   int                           idx;

   assign out_free = ~out_valid | wb_ready_i;

   // First full buffer at or after rr_ptr, wrapping around.
   always_comb begin
      grant   = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int k = 0; k < NrPorts; k++) begin
         idx = (int'(rr_ptr) + k) % NrPorts;
         if (!gnt_any && buf_valid[idx] && out_free && !flush_i) begin
            gnt_any = 1'b1;
            gnt_idx = PW'(idx);
         end
      end
      if (gnt_any) grant[gnt_idx] = 1'b1;
   end

   always_comb begin
      nxt_ptr = gnt_idx + 1'b1;
      if (int'(gnt_idx) == NrPorts - 1) nxt_ptr = '0;
   end

   assign req_ready_o = flush_i ? '0 : (~buf_valid | grant);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buf_valid  <= '0;
         buf_result <= '0;
         buf_tid    <= '0;
         buf_exc    <= '0;
      end else begin
         for (int i = 0; i < NrPorts; i++) begin
            if (req_valid_i[i] && req_ready_o[i]) begin
               buf_valid[i]  <= 1'b1;
               buf_result[i] <= req_result_i[i];
               buf_tid[i]    <= req_trans_id_i[i];
               buf_exc[i]    <= req_exception_i[i];
            end else if (grant[i] || flush_i) begin
               buf_valid[i]  <= 1'b0;
            end
         end
      end
   end

   // A grant implies out_free, so it may overwrite the output register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_tid    <= '0;
         out_exc    <= '0;
         out_src    <= '0;
         rr_ptr     <= '0;
      end else if (flush_i) begin
         out_valid  <= 1'b0;
      end else if (gnt_any) begin
         out_valid  <= 1'b1;
         out_result <= buf_result[gnt_idx];
         out_tid    <= buf_tid[gnt_idx];
         out_exc    <= buf_exc[gnt_idx];
         out_src    <= gnt_idx;
         rr_ptr     <= nxt_ptr;
      end else if (wb_ready_i) begin
         out_valid  <= 1'b0;
      end
   end

   assign wb_valid_o     = out_valid;
   assign wb_result_o    = out_result;
   assign wb_trans_id_o  = out_tid;
   assign wb_exception_o = out_exc;
   assign wb_src_o       = out_src;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with four requesters.
module tb_wb_port_arbiter;
   import wb_port_arbiter_pkg::*;

   localparam int N = 4;

   logic                   clk = 1'b0;
   logic                   rst_ni = 1'b0;
   logic                   flush = 1'b0;
   logic                   wb_ready = 1'b0;
   logic [N-1:0]           req_valid;
   logic [N-1:0]           req_ready;
   logic [N-1:0][XLEN-1:0] req_result;
   logic [N-1:0][2:0]      req_tid;
   exception_t [N-1:0]     req_exc;
   logic                   wb_valid;
   logic [XLEN-1:0]        wb_result;
   logic [2:0]             wb_tid;
   exception_t             wb_exc;
   logic [1:0]             wb_src;

   int vec_cnt = 0;
   int err_cnt = 0;

   wb_port_arbiter #(.NrPorts(N)) dut (
      .clk_i(clk),
      .rst_ni(rst_ni),
      .flush_i(flush),
      .req_valid_i(req_valid),
      .req_ready_o(req_ready),
      .req_result_i(req_result),
      .req_trans_id_i(req_tid),
      .req_exception_i(req_exc),
      .wb_valid_o(wb_valid),
      .wb_ready_i(wb_ready),
      .wb_result_o(wb_result),
      .wb_trans_id_o(wb_tid),
      .wb_exception_o(wb_exc),
      .wb_src_o(wb_src)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid  = '0;
      req_result = '0;
      req_tid    = '0;
      req_exc    = '0;
      flush      = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      wb_ready = 1'b0;
      rst_ni = 1'b0;
      step();
      step();
      rst_ni = 1'b1;
      step();
   endtask

   task automatic drive(input int p, input logic [63:0] r, input logic [2:0] t);
      req_valid[p]  = 1'b1;
      req_result[p] = r;
      req_tid[p]    = t;
   endtask

   task automatic test_reset();
      idle();
      rst_ni = 1'b0;
      step();
      step();
      vec_cnt++;
      if ({wb_valid, wb_src, wb_result, wb_tid, wb_exc} !== '0) begin
         err_cnt++;
         $display("FAIL reset_outputs: got v=%b src=%0d res=%h tid=%0d",
                  wb_valid, wb_src, wb_result, wb_tid);
      end
      rst_ni = 1'b1;
      step();
      vec_cnt++;
      if (req_ready !== 4'hF) begin
         err_cnt++;
         $display("FAIL reset_ready: got %b want 1111", req_ready);
      end
      flush = 1'b1;
      #1;
      vec_cnt++;
      if (req_ready !== 4'h0) begin
         err_cnt++;
         $display("FAIL flush_ready: got %b want 0000", req_ready);
      end
      flush = 1'b0;
      step();
   endtask

   task automatic test_single();
      do_reset();
      wb_ready = 1'b1;
      drive(2, 64'hDEAD, 3'd3);
      step();
      idle();
      vec_cnt++;
      if (wb_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL single_lat1: got valid %b want 0", wb_valid);
      end
      step();
      vec_cnt++;
      if ({wb_valid, wb_src, wb_result, wb_tid} !== {1'b1, 2'd2, 64'hDEAD, 3'd3}) begin
         err_cnt++;
         $display("FAIL single_wb: got v=%b src=%0d res=%h tid=%0d want 1/2/dead/3",
                  wb_valid, wb_src, wb_result, wb_tid);
      end
      step();
      vec_cnt++;
      if (wb_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL single_drop: got valid %b want 0", wb_valid);
      end
   endtask

   task automatic test_all_four();
      exception_t e;
      do_reset();
      wb_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         drive(i, 64'h100 + 64'(i), 3'(i));
         req_exc[i] = '{cause: 64'(i), tval: 64'hA0 + 64'(i), valid: i[0]};
      end
      step();
      idle();
      for (int i = 0; i < N; i++) begin
         step();
         e = '{cause: 64'(i), tval: 64'hA0 + 64'(i), valid: i[0]};
         vec_cnt++;
         if ({wb_valid, wb_src, wb_result, wb_tid, wb_exc} !==
             {1'b1, 2'(i), 64'h100 + 64'(i), 3'(i), e}) begin
            err_cnt++;
            $display("FAIL all_four[%0d]: got v=%b src=%0d res=%h tid=%0d exc=%h",
                     i, wb_valid, wb_src, wb_result, wb_tid, wb_exc);
         end
      end
      step();
      vec_cnt++;
      if (wb_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL all_four_end: got valid %b want 0", wb_valid);
      end
      drive(1, 64'h201, 3'd1);
      drive(3, 64'h203, 3'd3);
      step();
      idle();
      step();
      vec_cnt++;
      if ({wb_valid, wb_src} !== {1'b1, 2'd1}) begin
         err_cnt++;
         $display("FAIL ptr_wrap_a: got v=%b src=%0d want 1/1", wb_valid, wb_src);
      end
      step();
      vec_cnt++;
      if ({wb_valid, wb_src, wb_result} !== {1'b1, 2'd3, 64'h203}) begin
         err_cnt++;
         $display("FAIL ptr_wrap_b: got v=%b src=%0d res=%h want 1/3/203",
                  wb_valid, wb_src, wb_result);
      end
      step();
   endtask

   task automatic test_backpressure();
      do_reset();
      wb_ready = 1'b0;
      drive(0, 64'h10, 3'd1);
      drive(1, 64'h11, 3'd2);
      step();
      idle();
      step();
      drive(0, 64'h20, 3'd4);
      step();
      idle();
      #1;
      for (int c = 0; c < 5; c++) begin
         vec_cnt++;
         if ({wb_valid, wb_src, wb_result, wb_tid, req_ready[1:0]} !==
             {1'b1, 2'd0, 64'h10, 3'd1, 2'b00}) begin
            err_cnt++;
            $display("FAIL stall[%0d]: got v=%b src=%0d res=%h tid=%0d rdy=%b",
                     c, wb_valid, wb_src, wb_result, wb_tid, req_ready[1:0]);
         end
         step();
      end
      wb_ready = 1'b1;
      step();
      vec_cnt++;
      if ({wb_valid, wb_src, wb_result, wb_tid} !== {1'b1, 2'd1, 64'h11, 3'd2}) begin
         err_cnt++;
         $display("FAIL release_p1: got v=%b src=%0d res=%h tid=%0d",
                  wb_valid, wb_src, wb_result, wb_tid);
      end
      step();
      vec_cnt++;
      if ({wb_valid, wb_src, wb_result, wb_tid} !== {1'b1, 2'd0, 64'h20, 3'd4}) begin
         err_cnt++;
         $display("FAIL release_p0: got v=%b src=%0d res=%h tid=%0d",
                  wb_valid, wb_src, wb_result, wb_tid);
      end
      step();
   endtask

   task automatic test_fairness();
      do_reset();
      wb_ready = 1'b1;
      drive(0, 64'hA, 3'd1);
      drive(3, 64'h3, 3'd3);
      step();
      req_valid[3] = 1'b0;
      drive(0, 64'hB, 3'd2);
      step();
      vec_cnt++;
      if ({wb_valid, wb_src, wb_result, wb_tid} !== {1'b1, 2'd0, 64'hA, 3'd1}) begin
         err_cnt++;
         $display("FAIL fair_0a: got v=%b src=%0d res=%h tid=%0d",
                  wb_valid, wb_src, wb_result, wb_tid);
      end
      step();
      vec_cnt++;
      if ({wb_valid, wb_src, wb_result, wb_tid} !== {1'b1, 2'd3, 64'h3, 3'd3}) begin
         err_cnt++;
         $display("FAIL fair_3: got v=%b src=%0d res=%h tid=%0d",
                  wb_valid, wb_src, wb_result, wb_tid);
      end
      drive(0, 64'hC, 3'd5);
      step();
      vec_cnt++;
      if ({wb_valid, wb_src, wb_result, wb_tid} !== {1'b1, 2'd0, 64'hB, 3'd2}) begin
         err_cnt++;
         $display("FAIL fair_0b: got v=%b src=%0d res=%h tid=%0d",
                  wb_valid, wb_src, wb_result, wb_tid);
      end
      idle();
      step();
      vec_cnt++;
      if ({wb_valid, wb_src, wb_result, wb_tid} !== {1'b1, 2'd0, 64'hC, 3'd5}) begin
         err_cnt++;
         $display("FAIL fair_0c: got v=%b src=%0d res=%h tid=%0d",
                  wb_valid, wb_src, wb_result, wb_tid);
      end
      step();
      vec_cnt++;
      if (wb_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL fair_end: got valid %b want 0", wb_valid);
      end
   endtask

   task automatic test_flush();
      do_reset();
      wb_ready = 1'b0;
      drive(0, 64'h50, 3'd5);
      drive(1, 64'h51, 3'd6);
      drive(2, 64'h52, 3'd7);
      step();
      idle();
      step();
      vec_cnt++;
      if ({wb_valid, wb_src} !== {1'b1, 2'd0}) begin
         err_cnt++;
         $display("FAIL flush_pre: got v=%b src=%0d want 1/0", wb_valid, wb_src);
      end
      flush = 1'b1;
      drive(3, 64'h53, 3'd0);
      #1;
      vec_cnt++;
      if (req_ready !== 4'h0) begin
         err_cnt++;
         $display("FAIL flush_block: got rdy %b want 0000", req_ready);
      end
      step();
      idle();
      #1;
      vec_cnt++;
      if ({wb_valid, req_ready} !== {1'b0, 4'hF}) begin
         err_cnt++;
         $display("FAIL flush_after: got v=%b rdy=%b want 0/1111", wb_valid, req_ready);
      end
      wb_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         vec_cnt++;
         if (wb_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_ghost[%0d]: got v=%b tid=%0d want no writeback",
                     c, wb_valid, wb_tid);
         end
      end
      drive(0, 64'h60, 3'd1);
      drive(1, 64'h61, 3'd2);
      step();
      idle();
      step();
      vec_cnt++;
      if ({wb_valid, wb_src, wb_result} !== {1'b1, 2'd1, 64'h61}) begin
         err_cnt++;
         $display("FAIL flush_ptr: got v=%b src=%0d res=%h want 1/1/61",
                  wb_valid, wb_src, wb_result);
      end
      step();
      step();
   endtask

   task automatic test_reset_mid();
      do_reset();
      wb_ready = 1'b0;
      drive(0, 64'h70, 3'd1);
      drive(1, 64'h71, 3'd2);
      drive(2, 64'h72, 3'd3);
      step();
      idle();
      step();
      drive(3, 64'h73, 3'd4);
      #2;
      rst_ni = 1'b0;
      #1;
      vec_cnt++;
      if ({wb_valid, wb_src, wb_result, wb_tid, wb_exc} !== '0) begin
         err_cnt++;
         $display("FAIL rst_mid: got v=%b src=%0d res=%h tid=%0d want all 0",
                  wb_valid, wb_src, wb_result, wb_tid);
      end
      idle();
      step();
      step();
      rst_ni = 1'b1;
      wb_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         vec_cnt++;
         if (wb_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_ghost[%0d]: got v=%b tid=%0d want no writeback",
                     c, wb_valid, wb_tid);
         end
      end
      drive(0, 64'h80, 3'd1);
      drive(3, 64'h83, 3'd2);
      step();
      idle();
      step();
      vec_cnt++;
      if ({wb_valid, wb_src, wb_result} !== {1'b1, 2'd0, 64'h80}) begin
         err_cnt++;
         $display("FAIL rst_ptr_a: got v=%b src=%0d res=%h want 1/0/80",
                  wb_valid, wb_src, wb_result);
      end
      step();
      vec_cnt++;
      if ({wb_valid, wb_src, wb_result} !== {1'b1, 2'd3, 64'h83}) begin
         err_cnt++;
         $display("FAIL rst_ptr_b: got v=%b src=%0d res=%h want 1/3/83",
                  wb_valid, wb_src, wb_result);
      end
      step();
   endtask

   initial begin
      idle();
      test_reset();
      test_single();
      test_all_four();
      test_backpressure();
      test_fairness();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, core configuration.
REQ-002 SHALL have parameter NrPorts, default 4, number of result requesters; legal range 2..8.
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  pipeline flush; discards all buffered results.
REQ-006 SHALL have port req_valid_i  input  NrPorts  per-requester result valid.
REQ-007 SHALL have port req_ready_o  output  NrPorts  per-requester buffer can accept.
REQ-008 SHALL have port req_result_i  input  NrPorts x riscv::XLEN  per-requester result data.
REQ-009 SHALL have port req_trans_id_i  input  NrPorts x TRANS_ID_BITS  scoreboard entry per requester.
REQ-010 SHALL have port req_exception_i  input  NrPorts x exception_t  per-requester exception.
REQ-011 SHALL have port wb_valid_o  output  1  shared writeback port valid.
REQ-012 SHALL have port wb_ready_i  input  1  scoreboard accepts writeback.
REQ-013 SHALL have port wb_result_o  output  riscv::XLEN  writeback data.
REQ-014 SHALL have port wb_trans_id_o  output  TRANS_ID_BITS  writeback scoreboard entry.
REQ-015 SHALL have port wb_exception_o  output  exception_t  writeback exception.
REQ-016 SHALL have port wb_src_o  output  $clog2(NrPorts)  index of requester that produced the current writeback.

Function
REQ-017 SHALL hold one 1-entry buffer per requester (valid bit, result, trans_id, exception).
REQ-018 SHALL hold one output register (valid, result, trans_id, exception, src) driving all wb_* outputs directly; no combinational path from req_* to wb_*.
REQ-019 SHALL define out_free = ~out_valid | wb_ready_i.
REQ-020 SHALL, when out_free, grant the first full buffer at or after rr_ptr in ascending index order with wrap-around; no grant when no buffer full or ~out_free.
REQ-021 SHALL, on grant to index g, load buffer g into the output register, clear buffer g, set rr_ptr <= (g+1) mod NrPorts.
REQ-022 SHALL leave rr_ptr unchanged in cycles without a grant.
REQ-023 SHALL drive req_ready_o[i] = ~buf_valid[i] | grant[i], and SHALL force it 0 while flush_i is high.
REQ-024 SHALL capture requester i into buffer i when req_valid_i[i] & req_ready_o[i]; a same-cycle grant and capture on i leaves buffer i full with the new entry.
REQ-025 SHALL clear out_valid when wb_ready_i & out_valid and no grant occurs that cycle.
REQ-026 SHALL have minimum latency of 2 cycles from req handshake to wb_valid_o (capture edge, then grant edge).
REQ-027 SHALL keep wb_* outputs stable while wb_valid_o & ~wb_ready_i.
REQ-028 SHALL, in a cycle with flush_i high, clear all buffer valids and out_valid at the next edge, perform no grant, accept no input; rr_ptr is retained.
REQ-029 SHALL never lose, duplicate or reorder results from one requester; cross-requester order follows grant order.
REQ-030 SHALL guarantee each full buffer is granted within NrPorts grants (starvation-free).

Reset
REQ-031 SHALL, on rst_ni low, asynchronously clear all buffer valids, out_valid (wb_valid_o=0), rr_ptr=0, wb_src_o=0, wb_result_o=0, wb_trans_id_o=0, wb_exception_o=0.
REQ-032 SHALL drive req_ready_o all-ones in the first cycle after reset release with flush_i low.
REQ-033 SHALL discard any in-flight handshake when reset asserts mid-operation; no writeback after release without new requests.

Verification
REQ-034 Single request: port 2 valid, result=0xDEAD, trans_id=3, wb_ready_i=1 -> wb_valid_o=1 two cycles later, wb_result_o=0xDEAD, wb_trans_id_o=3, wb_src_o=2, then 0.
REQ-035 All four ports valid same cycle, rr_ptr=0, wb_ready_i=1 -> writebacks on four consecutive cycles, wb_src_o=0,1,2,3; rr_ptr ends 0.
REQ-036 Back-pressure: wb_ready_i=0 for 5 cycles with ports 0 and 1 full -> wb_* constant, req_ready_o[0]=req_ready_o[1]=0; after wb_ready_i=1 port 1 written next cycle.
REQ-037 Fairness: port 0 valid every cycle, port 3 valid once -> port 3 written no later than second grant after its capture; wb_src_o alternates 0,3,0.
REQ-038 Flush: buffers 1,2 full and out_valid=1, flush_i one cycle -> next cycle wb_valid_o=0, req_ready_o all-ones, no writeback of flushed trans_ids ever.
REQ-039 Reset mid-stream: rst_ni low while output and two buffers full -> wb_valid_o=0 immediately, rr_ptr=0, no writeback after release.
